// File: rtl/uart_rx_pkg.sv
// Shared UART definitions: FSM state encoding, default line settings and
// the baud divisor formula used by both the transmitter and the receiver.
package uart_rx_pkg;

    localparam int unsigned CLK_FREQ_DEF   = 100_000_000;
    localparam int unsigned BAUD_DEF       = 9600;
    localparam int unsigned OVERSAMPLE_DEF = 16;
    localparam int unsigned DATA_W         = 8;
    localparam int unsigned TICK_CNT_W     = 4;
    localparam int unsigned BIT_CNT_W      = 3;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_START = 3'd1,
        ST_DATA  = 3'd2,
        ST_STOP  = 3'd3,
        ST_BREAK = 3'd4
    } state_e;

    // Integer-truncated clocks per oversample tick.
    function automatic int unsigned baud_div(input int unsigned clk_freq,
                                             input int unsigned baud,
                                             input int unsigned oversample);
        return clk_freq / (baud * oversample);
    endfunction

endpackage

// File: rtl/baud_tick_gen.sv
// Free-running oversample tick generator; one-cycle tick every DIV clocks,
// never resynchronised to line activity.
module baud_tick_gen
    import uart_rx_pkg::*;
#(
    parameter int unsigned CLK_FREQ   = CLK_FREQ_DEF,
    parameter int unsigned BAUD       = BAUD_DEF,
    parameter int unsigned OVERSAMPLE = OVERSAMPLE_DEF
) (
    input  logic clk,
    input  logic rst,
    output logic tick
);

    localparam int unsigned DIV   = baud_div(CLK_FREQ, BAUD, OVERSAMPLE);
    localparam int unsigned CNT_W = (DIV > 1) ? $clog2(DIV) : 1;

    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             tick_q, tick_d;

    always_comb begin
        cnt_d  = cnt_q + CNT_W'(1);
        tick_d = 1'b0;
        if (cnt_q == CNT_W'(DIV - 1)) begin
            cnt_d  = '0;
            tick_d = 1'b1;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt_q  <= '0;
            tick_q <= 1'b0;
        end else begin
            cnt_q  <= cnt_d;
            tick_q <= tick_d;
        end
    end

    assign tick = tick_q;

endmodule

// File: rtl/uart_rx.sv
// 8N1 UART receiver with 16x oversampling, mid-bit sampling and a BREAK
// state that holds off new frames while the line stays low after a bad stop.
module uart_rx
    import uart_rx_pkg::*;
#(
    parameter int unsigned CLK_FREQ   = CLK_FREQ_DEF,
    parameter int unsigned BAUD       = BAUD_DEF,
    parameter int unsigned OVERSAMPLE = OVERSAMPLE_DEF
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              rx,
    output logic [DATA_W-1:0] rx_data,
    output logic              rx_done,
    output logic              rx_busy,
    output logic              frame_err
);

    logic [1:0] sync_q;
    logic       rx_s;
    logic       tick;

    state_e                state_q, state_d;
    logic [TICK_CNT_W-1:0] tick_cnt_q, tick_cnt_d;
    logic [BIT_CNT_W-1:0]  bit_cnt_q, bit_cnt_d;
    logic [DATA_W-1:0]     shreg_q, shreg_d;
    logic [DATA_W-1:0]     rx_data_q, rx_data_d;
    logic                  rx_done_q, rx_done_d;
    logic                  frame_err_q, frame_err_d;
    logic                  rx_busy_q;

    // Two-flop synchronizer, reset to the idle-high line level.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sync_q <= 2'b11;
        end else begin
            sync_q <= {sync_q[0], rx};
        end
    end
    assign rx_s = sync_q[1];

    baud_tick_gen #(
        .CLK_FREQ   (CLK_FREQ),
        .BAUD       (BAUD),
        .OVERSAMPLE (OVERSAMPLE)
    ) u_tick (
        .clk  (clk),
        .rst  (rst),
        .tick (tick)
    );

    always_comb begin
        state_d     = state_q;
        tick_cnt_d  = tick_cnt_q;
        bit_cnt_d   = bit_cnt_q;
        shreg_d     = shreg_q;
        rx_data_d   = rx_data_q;
        rx_done_d   = 1'b0;
        frame_err_d = 1'b0;

        case (state_q)
            ST_IDLE: begin
                if (!rx_s) begin
                    state_d    = ST_START;
                    tick_cnt_d = '0;
                end
            end
            ST_START: begin
                if (tick) begin
                    if (tick_cnt_q == TICK_CNT_W'(7)) begin
                        if (!rx_s) begin
                            state_d    = ST_DATA;
                            tick_cnt_d = '0;
                            bit_cnt_d  = '0;
                        end else begin
                            state_d = ST_IDLE;
                        end
                    end else begin
                        tick_cnt_d = tick_cnt_q + TICK_CNT_W'(1);
                    end
                end
            end
            ST_DATA: begin
                if (tick) begin
                    tick_cnt_d = tick_cnt_q + TICK_CNT_W'(1);
                    if (tick_cnt_q == TICK_CNT_W'(15)) begin
                        shreg_d = {rx_s, shreg_q[DATA_W-1:1]};
                        if (bit_cnt_q == BIT_CNT_W'(7)) begin
                            state_d = ST_STOP;
                        end else begin
                            bit_cnt_d = bit_cnt_q + BIT_CNT_W'(1);
                        end
                    end
                end
            end
            ST_STOP: begin
                if (tick) begin
                    tick_cnt_d = tick_cnt_q + TICK_CNT_W'(1);
                    if (tick_cnt_q == TICK_CNT_W'(15)) begin
                        if (rx_s) begin
                            rx_data_d = shreg_q;
                            rx_done_d = 1'b1;
                            state_d   = ST_IDLE;
                        end else begin
                            frame_err_d = 1'b1;
                            state_d     = ST_BREAK;
                        end
                    end
                end
            end
            ST_BREAK: begin
                if (rx_s) begin
                    state_d = ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= ST_IDLE;
            tick_cnt_q  <= '0;
            bit_cnt_q   <= '0;
            shreg_q     <= '0;
            rx_data_q   <= '0;
            rx_done_q   <= 1'b0;
            frame_err_q <= 1'b0;
            rx_busy_q   <= 1'b0;
        end else begin
            state_q     <= state_d;
            tick_cnt_q  <= tick_cnt_d;
            bit_cnt_q   <= bit_cnt_d;
            shreg_q     <= shreg_d;
            rx_data_q   <= rx_data_d;
            rx_done_q   <= rx_done_d;
            frame_err_q <= frame_err_d;
            rx_busy_q   <= (state_d != ST_IDLE);
        end
    end

    assign rx_data   = rx_data_q;
    assign rx_done   = rx_done_q;
    assign rx_busy   = rx_busy_q;
    assign frame_err = frame_err_q;

endmodule

// File: tb/tb_uart_rx.sv
// Scoreboard bench for uart_rx: stimulus queues expected events, a negedge
// monitor pops and checks each rx_done / frame_err pulse.
module tb_uart_rx;

    // DIV = 32e6 / (250e3 * 16) = 8 clocks per tick, 128 clocks per bit.
    localparam int unsigned CLK_FREQ = 32_000_000;
    localparam int unsigned BAUD     = 250_000;
    localparam int          BIT_P    = 128;
    localparam longint      LAT_MIN  = 1204;
    localparam longint      LAT_MAX  = 1228;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       rx  = 1'b1;
    logic [7:0] rx_data;
    logic       rx_done;
    logic       rx_busy;
    logic       frame_err;

    typedef struct {
        bit         is_err;
        logic [7:0] data;
        bit         chk_lat;
        longint     edge_cyc;
    } exp_t;

    exp_t       sb_q[$];
    int         n_cmp = 0;
    int         n_fail = 0;
    longint     cyc = 0;
    logic [7:0] last_data = '0;

    uart_rx #(
        .CLK_FREQ (CLK_FREQ),
        .BAUD     (BAUD)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .rx        (rx),
        .rx_data   (rx_data),
        .rx_done   (rx_done),
        .rx_busy   (rx_busy),
        .frame_err (frame_err)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, want 0x%0h", name, act, exp);
        end
    endtask

    task automatic chk_range(input string name, input longint v, input longint lo, input longint hi);
        n_cmp++;
        if (v < lo || v > hi) begin
            n_fail++;
            $display("FAIL %s: got %0d, want %0d..%0d", name, v, lo, hi);
        end
    endtask

    task automatic wait_cyc(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    // Drive one 8N1 frame with bit period p clocks and queue its expected event.
    task automatic send_frame(input logic [7:0] d, input int p, input bit stop_b,
                              input bit lat, input bit busy_chk);
        exp_t       e;
        logic [9:0] bits;
        bits       = {stop_b, d, 1'b0};
        e.is_err   = !stop_b;
        e.data     = stop_b ? d : last_data;
        e.chk_lat  = lat;
        e.edge_cyc = cyc;
        sb_q.push_back(e);
        if (stop_b) last_data = d;
        for (int i = 0; i < 10; i++) begin
            rx = bits[i];
            wait_cyc(p / 2);
            if (busy_chk && i < 9) chk($sformatf("busy_bit%0d", i), 32'(rx_busy), 32'd1);
            wait_cyc(p - p / 2);
        end
    endtask

    always @(negedge clk) begin
        if (!rst && (rx_done || frame_err)) begin
            exp_t e;
            chk("done_ferr_exclusive", 32'(rx_done & frame_err), 32'd0);
            if (sb_q.size() == 0) begin
                n_cmp++;
                n_fail++;
                $display("FAIL unexpected_event: done=%0b ferr=%0b data=0x%02h, want no event",
                         rx_done, frame_err, rx_data);
            end else begin
                e = sb_q.pop_front();
                chk("event_is_frame_err", 32'(frame_err), 32'(e.is_err));
                chk("rx_data", 32'(rx_data), 32'(e.data));
                if (e.chk_lat) chk_range("start_to_done_latency", cyc - e.edge_cyc, LAT_MIN, LAT_MAX);
            end
        end
    end

    initial begin
        int k;
        rst = 1'b1;
        rx  = 1'b1;
        wait_cyc(5);
        chk("reset_rx_data", 32'(rx_data), 32'd0);
        chk("reset_rx_done", 32'(rx_done), 32'd0);
        chk("reset_rx_busy", 32'(rx_busy), 32'd0);
        chk("reset_frame_err", 32'(frame_err), 32'd0);
        rst = 1'b0;
        wait_cyc(2 * BIT_P);

        send_frame(8'h31, BIT_P, 1'b1, 1'b1, 1'b1);
        wait_cyc(2 * BIT_P);
        chk("idle_after_31", 32'(rx_busy), 32'd0);

        send_frame(8'h55, BIT_P, 1'b1, 1'b1, 1'b0);
        send_frame(8'hAA, BIT_P, 1'b1, 1'b1, 1'b0);
        wait_cyc(2 * BIT_P);

        // Short low glitch: start is entered then rejected at mid start bit.
        rx = 1'b0;
        wait_cyc(4);
        chk("glitch_busy_rose", 32'(rx_busy), 32'd1);
        rx = 1'b1;
        k = 0;
        while (rx_busy && k < 80) begin
            wait_cyc(1);
            k++;
        end
        chk("glitch_busy_cleared", 32'(rx_busy), 32'd0);
        chk("glitch_rx_data_kept", 32'(rx_data), 32'(last_data));
        wait_cyc(2 * BIT_P);

        send_frame(8'hA5, BIT_P, 1'b0, 1'b0, 1'b0);
        wait_cyc(10 * BIT_P);
        chk("break_busy_held", 32'(rx_busy), 32'd1);
        wait_cyc(10 * BIT_P);
        rx = 1'b1;
        wait_cyc(2 * BIT_P);
        chk("break_released", 32'(rx_busy), 32'd0);
        send_frame(8'h3C, BIT_P, 1'b1, 1'b1, 1'b0);
        wait_cyc(2 * BIT_P);

        // Reset in the middle of data bit 4 of an aborted frame.
        rx = 1'b0;
        wait_cyc(BIT_P);
        for (int i = 0; i < 4; i++) begin
            rx = ((8'h5A >> i) & 8'h01) != 8'h00;
            wait_cyc(BIT_P);
        end
        rx = 1'b1;
        wait_cyc(BIT_P / 2);
        rst = 1'b1;
        #1;
        chk("midreset_rx_data", 32'(rx_data), 32'd0);
        chk("midreset_rx_busy", 32'(rx_busy), 32'd0);
        chk("midreset_rx_done", 32'(rx_done), 32'd0);
        chk("midreset_frame_err", 32'(frame_err), 32'd0);
        last_data = '0;
        wait_cyc(10);
        rst = 1'b0;
        wait_cyc(2 * BIT_P);
        send_frame(8'hC3, BIT_P, 1'b1, 1'b1, 1'b0);
        wait_cyc(2 * BIT_P);

        send_frame(8'h96, 124, 1'b1, 1'b0, 1'b0);
        wait_cyc(2 * BIT_P);
        send_frame(8'h96, 132, 1'b1, 1'b0, 1'b0);
        wait_cyc(4 * BIT_P);

        chk("scoreboard_drained", 32'(sb_q.size()), 32'd0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

    initial begin
        #400_000;
        n_cmp++;
        n_fail++;
        $display("FAIL watchdog: simulation still running at time %0t, want completion", $time);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
